// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit-over-16-bit SRAM controller.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_DATA_BASE = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage SRAM controller: one 32-bit access as two 16-bit half-accesses,
// low half first, each lasting PHASE_CYCLES clocks.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 2,
    parameter int unsigned DATA_BASE    = DEFAULT_DATA_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  logic [15:0] SRAM_DQ,
    output logic        SRAM_WE_N
);

    localparam int unsigned CW = $clog2(PHASE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_is_write;
    logic [16:0]   r_word;
    logic [31:0]   r_wdata;
    logic [31:0]   r_read_data;

    logic [31:0]   w_offset;
    logic          w_req;
    logic          w_phase;
    logic          w_last;
    logic          w_drive;
    logic          w_unused;

    assign w_req    = rd_en | wr_en;
    assign w_offset = address - 32'(DATA_BASE);
    // Byte-lane bits and offset bits above the 256K-word range are dropped on purpose.
    assign w_unused = ^{w_offset[31:19], w_offset[1:0]};
    assign w_phase  = (r_state == LOW) || (r_state == HIGH);
    assign w_last   = w_phase && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req)  w_next = LOW;
            LOW:     if (w_last) w_next = HIGH;
            HIGH:    if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_cnt <= (w_last || !w_phase) ? '0 : r_cnt + CW'(1);
            if (r_state == IDLE && w_req) begin
                r_is_write <= wr_en;
                r_word     <= w_offset[18:2];
                r_wdata    <= write_data;
            end
            if (w_last && !r_is_write) begin
                if (r_state == LOW) begin
                    r_read_data[15:0]  <= SRAM_DQ;
                end else begin
                    r_read_data[31:16] <= SRAM_DQ;
                end
            end
        end
    end

    assign ready     = ~w_req | (r_state == DONE);
    assign read_data = r_read_data;
    assign SRAM_ADDR = {r_word, r_state == HIGH};
    assign w_drive   = r_is_write && w_phase;
    // WE_N rises at the start of the terminal cycle while address and data are still held.
    assign SRAM_WE_N = ~(w_drive && !w_last);
    assign SRAM_DQ   = w_drive ? ((r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0]) : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed vector table, reset-abort sequence and
// randomized accesses against a word-addressed reference memory.
module sram_model (
    input  logic [17:0] addr,
    inout  logic [15:0] dq,
    input  logic        we_n,
    input  logic        oe
);
    logic [15:0] mem [0:262143];

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = '0;
    end

    assign dq = (oe && we_n) ? mem[addr] : 'z;

    always @(posedge we_n) mem[addr] <= dq;
endmodule

module tb_sram_controller;

    localparam int unsigned P    = 2;
    localparam int unsigned BASE = 1024;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    tri1  [15:0] SRAM_DQ;
    logic        SRAM_WE_N;
    logic        sram_oe;

    int n_tests;
    int n_fail;

    logic [15:0] ref_mem [int unsigned];
    logic [31:0] last_read;

    sram_controller #(.PHASE_CYCLES(P), .DATA_BASE(BASE)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    sram_model u_mem (
        .addr (SRAM_ADDR),
        .dq   (SRAM_DQ),
        .we_n (SRAM_WE_N),
        .oe   (sram_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned ref_word(input logic [31:0] a);
        return ((a - BASE) >> 2) & 32'h1FFFF;
    endfunction

    function automatic logic [15:0] ref_get(input int unsigned idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 16'h0000;
    endfunction

    task automatic idle_checks(input string tag);
        check({tag, "_ready"}, ready, 1'b1);
        check({tag, "_we_n"}, SRAM_WE_N, 1'b1);
        check({tag, "_dq_z"}, SRAM_DQ, 16'hFFFF);
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit scramble);
        int unsigned w;
        logic        hi;
        logic        term;
        w = ref_word(addr);
        rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
        sram_oe = !wr;
        for (int k = 0; k <= 2 * P + 1; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (scramble && k <= 2 * P) begin
                    rd_en = 1'($urandom); wr_en = 1'($urandom);
                    address = $urandom; write_data = $urandom;
                end
                if (k == 2 * P + 1) begin
                    rd_en = rd; wr_en = wr;
                end
            end
            @(negedge clk);
            check("ready", ready, (k == 2 * P + 1) || !(rd_en || wr_en));
            if (k >= 1 && k <= 2 * P) begin
                hi   = (k > P);
                term = (k == P) || (k == 2 * P);
                check("sram_addr", SRAM_ADDR, {w[16:0], hi});
                check("we_n", SRAM_WE_N, !(wr && !term));
                if (wr) check("dq_drive", SRAM_DQ, hi ? wdata[31:16] : wdata[15:0]);
            end
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; sram_oe = 1'b0;
        if (wr) begin
            ref_mem[2 * w]     = wdata[15:0];
            ref_mem[2 * w + 1] = wdata[31:16];
        end else begin
            last_read = {ref_get(2 * w + 1), ref_get(2 * w)};
        end
        @(negedge clk);
        check("read_data", read_data, last_read);
        idle_checks("post");
        if (wr) begin
            check("mem_lo", u_mem.mem[2 * w], wdata[15:0]);
            check("mem_hi", u_mem.mem[2 * w + 1], wdata[31:16]);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        n_tests = 0; n_fail = 0; last_read = '0;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0; sram_oe = 1'b0;

        vecs[0]  = '{1'b0, 1'b1, 32'd1024,    32'd1546,      32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'd1024,    32'h0,         32'h0000_060A};
        vecs[2]  = '{1'b0, 1'b1, 32'd1028,    32'hFFFF_F9F6, 32'h0000_060A};
        vecs[3]  = '{1'b1, 1'b0, 32'd1028,    32'h0,         32'hFFFF_F9F6};
        vecs[4]  = '{1'b1, 1'b0, 32'd1544,    32'h0,         32'h0000_0000};
        vecs[5]  = '{1'b1, 1'b1, 32'd1032,    32'h1234_5678, 32'h0000_0000};
        vecs[6]  = '{1'b1, 1'b0, 32'd1032,    32'h0,         32'h1234_5678};
        vecs[7]  = '{1'b0, 1'b1, 32'h0008_040B, 32'hCAFE_BABE, 32'h1234_5678};
        vecs[8]  = '{1'b1, 1'b0, 32'd1032,    32'h0,         32'hCAFE_BABE};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_5A5A, 32'hCAFE_BABE};
        vecs[10] = '{1'b1, 1'b0, 32'h0008_0000, 32'h0,       32'hA5A5_5A5A};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_read_data", read_data, 32'h0);
            idle_checks("idle");
            @(posedge clk); #1;
        end

        for (int i = 0; i < 11; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0);
            check($sformatf("vec%0d_rdata", i), read_data, vecs[i].exp_rdata);
        end
        check("vec_mem0", u_mem.mem[0], 16'h060A);
        check("vec_mem1", u_mem.mem[1], 16'h0000);
        check("vec_mem3", u_mem.mem[3], 16'hFFFF);

        // Reset in the first HIGH cycle of a read aborts it and clears read_data.
        rd_en = 1'b1; address = 32'd1024; sram_oe = 1'b1;
        repeat (P + 1) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rd_en = 1'b0; sram_oe = 1'b0;
        @(negedge clk);
        check("abort_read_data", read_data, 32'h0);
        idle_checks("abort");
        @(posedge clk); #1;
        last_read = '0;
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        check("abort_reload", read_data, 32'h0000_060A);

        for (int i = 0; i < 150; i++) begin
            logic        rd;
            logic        wr;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
            access(rd, wr, a, $urandom, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
